rr_resp_router: RTL and testbench

- Return-path counterpart of the round-robin request arbiter. The arbiter funnels N requesters onto one shared channel; this block takes the single tagged response stream coming back and steers each beat to the originating port.
- Each port has a small per-port FIFO, so one stalled requester never blocks responses to the other ports.
- Sits between the shared memory/response channel and the N user ports, mirroring the arbiter's port order.

---
 rtl/rr_resp_router.sv | 100 ++++++++++
 tb/tb_rr_resp_router.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/rr_resp_router.sv
// Response router: steers a tagged response stream into N per-port FIFOs so that
// a stalled consumer never blocks responses headed for the other ports.
module rr_resp_router #(
    parameter int unsigned N      = 4,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned TAG_W  = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_in_valid,
    input  logic [TAG_W-1:0]      i_in_tag,
    input  logic [DATA_W-1:0]     i_in_data,
    output logic                  o_in_ready,
    output logic [N-1:0]          o_out_valid,
    output logic [N*DATA_W-1:0]   o_out_data,
    input  logic [N-1:0]          i_out_ready,
    output logic                  o_err_bad_tag,
    output logic [7:0]            o_drop_cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] r_mem    [N][DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr [N];
    logic [PTR_W-1:0]  r_rd_ptr [N];
    logic [CNT_W-1:0]  r_cnt    [N];
    logic              r_err_bad_tag;
    logic [7:0]        r_drop_cnt;

    logic [N-1:0] w_full;
    logic [N-1:0] w_push;
    logic [N-1:0] w_pop;
    logic         w_tag_ok;
    logic         w_bad_beat;

    assign w_tag_ok   = (32'(i_in_tag) < N);
    assign w_bad_beat = i_in_valid && !w_tag_ok;

    // Out-of-range tags match no port, so ready defaults to 1 and the beat is dropped.
    always_comb begin
        o_in_ready = 1'b1;
        for (int i = 0; i < int'(N); i++) begin
            if (i_in_tag == TAG_W'(i)) begin
                o_in_ready = !w_full[i];
            end
        end
    end

    for (genvar g = 0; g < int'(N); g++) begin : g_port
        assign w_full[g]      = (r_cnt[g] == CNT_W'(DEPTH));
        assign o_out_valid[g] = (r_cnt[g] != '0);
        assign w_push[g]      = i_in_valid && w_tag_ok && (i_in_tag == TAG_W'(g)) && !w_full[g];
        assign w_pop[g]       = o_out_valid[g] && i_out_ready[g];
        assign o_out_data[g*DATA_W +: DATA_W] = r_mem[g][r_rd_ptr[g]];

        always_ff @(posedge i_clk) begin
            if (w_push[g]) begin
                r_mem[g][r_wr_ptr[g]] <= i_in_data;
            end
        end

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_wr_ptr[g] <= '0;
                r_rd_ptr[g] <= '0;
                r_cnt[g]    <= '0;
            end else begin
                if (w_push[g]) begin
                    r_wr_ptr[g] <= r_wr_ptr[g] + PTR_W'(1);
                end
                if (w_pop[g]) begin
                    r_rd_ptr[g] <= r_rd_ptr[g] + PTR_W'(1);
                end
                case ({w_push[g], w_pop[g]})
                    2'b10:   r_cnt[g] <= r_cnt[g] + CNT_W'(1);
                    2'b01:   r_cnt[g] <= r_cnt[g] - CNT_W'(1);
                    default: r_cnt[g] <= r_cnt[g];
                endcase
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_err_bad_tag <= 1'b0;
            r_drop_cnt    <= '0;
        end else if (w_bad_beat) begin
            r_err_bad_tag <= 1'b1;
            if (r_drop_cnt != 8'hFF) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    assign o_err_bad_tag = r_err_bad_tag;
    assign o_drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_rr_resp_router.sv
// Bench for rr_resp_router: directed scenarios plus random traffic, all checked
// against per-port queues that model the routing rules directly.
module tb_rr_resp_router;

    localparam int unsigned N      = 4;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned TAG_W  = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic [TAG_W-1:0]    in_tag;
    logic [DATA_W-1:0]   in_data;
    logic                in_ready;
    logic [N-1:0]        out_valid;
    logic [N*DATA_W-1:0] out_data;
    logic [N-1:0]        out_ready;
    logic                err_bad_tag;
    logic [7:0]          drop_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [DATA_W-1:0] mq [N][$];
    logic              m_err;
    int                m_drop;

    rr_resp_router #(
        .N      (N),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .TAG_W  (TAG_W)
    ) u_dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_in_valid    (in_valid),
        .i_in_tag      (in_tag),
        .i_in_data     (in_data),
        .o_in_ready    (in_ready),
        .o_out_valid   (out_valid),
        .o_out_data    (out_data),
        .i_out_ready   (out_ready),
        .o_err_bad_tag (err_bad_tag),
        .o_drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DATA_W-1:0] got,
                         input logic [DATA_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic model_ready(input logic [TAG_W-1:0] t);
        if (int'(t) >= int'(N)) return 1'b1;
        return mq[t].size() < int'(DEPTH);
    endfunction

    // One clock: check state outputs, drive inputs, check in_ready, advance model.
    // Entered and left just after a falling edge.
    task automatic step(input logic v, input logic [TAG_W-1:0] t,
                        input logic [DATA_W-1:0] d, input logic [N-1:0] rdy,
                        input logic r);
        logic [N-1:0] exp_valid;
        logic         exp_rdy;
        logic         acc;
        for (int i = 0; i < int'(N); i++) begin
            exp_valid[i] = mq[i].size() > 0;
            if (exp_valid[i]) check("out_data", out_data[i*DATA_W +: DATA_W], mq[i][0]);
        end
        check("out_valid", DATA_W'(out_valid), DATA_W'(exp_valid));
        check("err_bad_tag", DATA_W'(err_bad_tag), DATA_W'(m_err));
        check("drop_cnt", DATA_W'(drop_cnt), DATA_W'(m_drop));
        rst       = r;
        in_valid  = v;
        in_tag    = t;
        in_data   = d;
        out_ready = rdy;
        #1;
        exp_rdy = model_ready(t);
        check("in_ready", DATA_W'(in_ready), DATA_W'(exp_rdy));
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < int'(N); i++) mq[i].delete();
            m_err  = 1'b0;
            m_drop = 0;
        end else begin
            acc = v && exp_rdy;
            for (int i = 0; i < int'(N); i++) begin
                if (rdy[i] && mq[i].size() > 0) void'(mq[i].pop_front());
            end
            if (acc) begin
                if (int'(t) < int'(N)) begin
                    mq[t].push_back(d);
                end else begin
                    m_err = 1'b1;
                    if (m_drop < 255) m_drop++;
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        m_err     = 1'b0;
        m_drop    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_tag    = '0;
        in_data   = '0;
        out_ready = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Idle after reset: every legal tag must see ready
        for (int t = 0; t < 4; t++) step(1'b0, TAG_W'(t), '0, '0, 1'b0);

        // Single beat to port 2 with all consumers ready
        step(1'b1, 3'd2, 64'hA5, 4'hF, 1'b0);
        check("single_valid", DATA_W'(out_valid), DATA_W'(4'b0100));
        check("single_data", out_data[2*DATA_W +: DATA_W], 64'hA5);
        step(1'b0, 3'd0, '0, 4'hF, 1'b0);
        check("single_drained", DATA_W'(out_valid), '0);

        // Fill port 1, hold a fifth beat, then release the consumer
        for (int k = 0; k < 4; k++) step(1'b1, 3'd1, 64'h10 + k, 4'h0, 1'b0);
        step(1'b1, 3'd1, 64'h14, 4'h0, 1'b0);
        check("full_blocks_tag1", DATA_W'(in_ready), '0);
        step(1'b0, 3'd0, '0, 4'h0, 1'b0);
        check("tag0_ready_while_p1_full", DATA_W'(in_ready), 64'd1);
        step(1'b1, 3'd1, 64'h14, 4'h2, 1'b0);
        for (int k = 0; k < 6; k++) step(1'b0, 3'd1, '0, 4'h2, 1'b0);

        // Interleaved ports 0 and 3, only port 3 draining
        step(1'b1, 3'd0, 64'd1, 4'h8, 1'b0);
        step(1'b1, 3'd3, 64'd2, 4'h8, 1'b0);
        step(1'b1, 3'd0, 64'd3, 4'h8, 1'b0);
        step(1'b1, 3'd3, 64'd4, 4'h8, 1'b0);
        step(1'b0, 3'd0, '0, 4'h8, 1'b0);
        check("p0_holds_first", out_data[0 +: DATA_W], 64'd1);
        for (int k = 0; k < 3; k++) step(1'b0, 3'd0, '0, 4'h9, 1'b0);

        // Bad tags: dropped, sticky error, saturating counter
        step(1'b1, 3'd5, 64'hFF, 4'hF, 1'b0);
        check("bad_err", DATA_W'(err_bad_tag), 64'd1);
        check("bad_cnt1", DATA_W'(drop_cnt), 64'd1);
        for (int k = 0; k < 299; k++) step(1'b1, TAG_W'(4 + (k % 4)), 64'(k), 4'hF, 1'b0);
        check("drop_sat", DATA_W'(drop_cnt), 64'd255);

        // Reset mid-operation discards buffered beats
        for (int k = 0; k < 3; k++) step(1'b1, 3'd0, 64'h30 + k, 4'h0, 1'b0);
        step(1'b0, 3'd0, '0, 4'h0, 1'b1);
        check("rst_out_valid", DATA_W'(out_valid), '0);
        check("rst_err", DATA_W'(err_bad_tag), '0);
        step(1'b1, 3'd0, 64'h77, 4'h0, 1'b0);
        check("post_rst_data", out_data[0 +: DATA_W], 64'h77);
        step(1'b0, 3'd0, '0, 4'h1, 1'b0);
        check("post_rst_sole", DATA_W'(out_valid), '0);

        // Random traffic, mostly legal tags, sparse reset
        for (int k = 0; k < 3000; k++) begin
            logic [TAG_W-1:0] t;
            t = ($urandom_range(0, 7) == 0) ? TAG_W'($urandom_range(4, 7))
                                             : TAG_W'($urandom_range(0, 3));
            step(1'($urandom_range(0, 3) != 0), t, {$urandom, $urandom},
                 N'($urandom), 1'($urandom_range(0, 499) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
